// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parameterised serial pattern detector.
package seq_det_pkg;

  // Legal range of the pattern length parameter
  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;

  // Pattern loaded at reset when the instance does not override it
  localparam logic [3:0] DEF_PAT = 4'b1011;

  // Width of the fill counter that holds values 0..len-1
  function automatic int fill_width(input int len);
    return (len > 2) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter with synchronous clear; clear wins over increment.
module seq_det_match_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count hits, hold at all-ones, clear on reset or clr
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with run-time loadable pattern and selectable
// overlapping / non-overlapping detection. match is a registered Mealy pulse.
// Optional feature macro: SEQ_DET_MATCH_CNT_EN adds cnt_clr / match_cnt and a
// saturating hit counter.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PAT_INIT = DEF_PAT,
  parameter int                 CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  input  logic               in_bit,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_data,
`ifdef SEQ_DET_MATCH_CNT_EN
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   match_cnt,
`endif
  output logic               match
);

  localparam int                FILL_W    = fill_width(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);

  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX || CNT_W < 1) begin : g_bad_param
    $error("seq_detect_param: PAT_LEN or CNT_W out of range");
  end

  logic [PAT_LEN-1:0] pat;
  logic [PAT_LEN-2:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [PAT_LEN-1:0] cand;
  logic               hit;

  // Candidate window and hit decision; a bit arriving with pat_load is dropped
  always_comb begin
    cand = {hist, in_bit};
    hit  = 1'b0;
    if (in_vld && !pat_load && (fill == FILL_FULL) && (cand == pat)) begin
      hit = 1'b1;
    end
  end

  // Pattern, history and fill bookkeeping plus the registered match pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      pat   <= PAT_INIT;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      match <= hit;
      if (pat_load) begin
        pat  <= pat_data;
        fill <= '0;
      end else if (in_vld) begin
        hist <= cand[PAT_LEN-2:0];
        if (hit && !overlap) begin
          fill <= '0;
        end else if (fill != FILL_FULL) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  seq_det_match_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (hit),
    .cnt (match_cnt)
  );
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed, table-driven bench for seq_detect_param (default 4-bit pattern
// 1011). Counter checks are compiled in with SEQ_DET_MATCH_CNT_EN.
module tb_seq_detect_param;

  localparam int CNT_W_TB = 2;

  typedef struct {
    bit       r;
    bit       v;
    bit       b;
    bit       o;
    bit       l;
    bit [3:0] d;
    bit       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_vld = 1'b0;
  logic       in_bit = 1'b0;
  logic       overlap = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_data = 4'b0000;
  logic       match;
`ifdef SEQ_DET_MATCH_CNT_EN
  logic                cnt_clr = 1'b0;
  logic [CNT_W_TB-1:0] match_cnt;
`endif

  int   nvec  = 0;
  int   nfail = 0;
  vec_t vq[$];

  seq_detect_param #(
    .PAT_LEN  (4),
    .PAT_INIT (4'b1011),
    .CNT_W    (CNT_W_TB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (in_vld),
    .in_bit    (in_bit),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_data  (pat_data),
`ifdef SEQ_DET_MATCH_CNT_EN
    .cnt_clr   (cnt_clr),
    .match_cnt (match_cnt),
`endif
    .match     (match)
  );

  always #5 clk = ~clk;

  task automatic add(input bit r, input bit v, input bit b, input bit o,
                     input bit l, input bit [3:0] d, input bit e);
    vec_t t;
    t.r = r; t.v = v; t.b = b; t.o = o; t.l = l; t.d = d; t.e = e;
    vq.push_back(t);
  endtask

  // Stream of consumed bits with expected match per bit
  task automatic add_bits(input string bits, input string exp, input bit o);
    for (int i = 0; i < bits.len(); i++)
      add(1'b0, 1'b1, bits[i] == "1", o, 1'b0, 4'b0000, exp[i] == "1");
  endtask

  // Drive one cycle at the falling edge, sample 1 time unit after the rising edge
  task automatic step(input vec_t t);
    @(negedge clk);
    rst = t.r; in_vld = t.v; in_bit = t.b; overlap = t.o;
    pat_load = t.l; pat_data = t.d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    nvec++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  initial begin
    // reset, then overlapping 1,0,1,1,0,1,1 -> hits on bits 4 and 7
    add(1, 0, 0, 0, 0, 4'b0000, 0);
    add_bits("1011011", "0001001", 1'b1);
    // non-overlapping 1,0,1,1,0,1,1,0,1,1 -> hits on bits 4 and 10
    add(1, 0, 0, 0, 0, 4'b0000, 0);
    add_bits("1011011011", "0001000001", 1'b0);
    // gap of in_vld=0 (with in_bit=1) inside the pattern
    add(1, 0, 0, 0, 0, 4'b0000, 0);
    add_bits("10", "00", 1'b1);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 1, 0, 4'b0000, 0);
    add_bits("11", "01", 1'b1);
    // pattern load mid-stream; the bit presented with the load is dropped
    add(1, 0, 0, 0, 0, 4'b0000, 0);
    add_bits("101", "000", 1'b1);
    add(0, 1, 1, 1, 1, 4'b0110, 0);
    add_bits("0110", "0001", 1'b1);
    add_bits("011", "000", 1'b1);
    add(0, 1, 0, 1, 1, 4'b0110, 0);
    add_bits("0110", "0001", 1'b1);
    // reset mid-pattern discards history
    add(1, 0, 0, 0, 0, 4'b0000, 0);
    add_bits("101", "000", 1'b1);
    add(1, 1, 1, 1, 0, 4'b0000, 0);
    add_bits("1", "0", 1'b1);
    add_bits("1011", "0001", 1'b1);
    // overlap mode changes take effect on the bit they accompany
    add(1, 0, 0, 0, 0, 4'b0000, 0);
    add_bits("1011", "0001", 1'b1);
    add_bits("01", "00", 1'b1);
    add_bits("1", "1", 1'b0);
    add_bits("011", "000", 1'b1);
    add_bits("011", "001", 1'b1);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i]);
      chk($sformatf("vec%0d match", i), int'(match), int'(vq[i].e));
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    begin
      vec_t t;
      string s;
      t.r = 1; t.v = 0; t.b = 0; t.o = 1; t.l = 0; t.d = 4'b0000; t.e = 0;
      step(t);
      chk("cnt reset", int'(match_cnt), 0);
      s = "1011011";
      t.r = 0; t.v = 1;
      for (int i = 0; i < s.len(); i++) begin
        t.b = (s[i] == "1");
        step(t);
      end
      chk("cnt two hits", int'(match_cnt), 2);
      s = "011011011";
      for (int i = 0; i < s.len(); i++) begin
        t.b = (s[i] == "1");
        step(t);
      end
      chk("match fifth hit", int'(match), 1);
      chk("cnt saturated", int'(match_cnt), 3);
      t.b = 0; step(t);
      t.b = 1; step(t);
      cnt_clr = 1'b1;
      t.b = 1; step(t);
      cnt_clr = 1'b0;
      chk("match with clr", int'(match), 1);
      chk("cnt clr beats hit", int'(match_cnt), 0);
      s = "011";
      for (int i = 0; i < s.len(); i++) begin
        t.b = (s[i] == "1");
        step(t);
      end
      chk("cnt after clr", int'(match_cnt), 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_LEN, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter PAT_INIT, default 4'b1011: pattern loaded at reset; MSB is the first bit received.
REQ-003 Parameter CNT_W, default 8: width of the match counter.
REQ-004 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 in_vld  in  1  serial bit strobe; the bit is consumed only when high.
REQ-007 in_bit  in  1  serial data bit.
REQ-008 overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled on each consumed bit.
REQ-009 pat_load  in  1  one-cycle strobe that loads a new pattern.
REQ-010 pat_data  in  PAT_LEN  new pattern; MSB is the first bit.
REQ-011 cnt_clr  in  1  clears the match counter (present only with MATCH_CNT_EN).
REQ-012 match  out  1  registered Mealy detection pulse.
REQ-013 match_cnt  out  CNT_W  saturating match count (present only with MATCH_CNT_EN).

Function
REQ-014 Internal state SHALL be: pattern register pat, history shift register hist (PAT_LEN-1 bits), fill counter fill (0..PAT_LEN-1).
REQ-015 A consumed bit SHALL form cand = {hist, in_bit}; a hit SHALL occur when fill == PAT_LEN-1 and cand == pat.
REQ-016 match SHALL be 1 in the cycle after the clock edge that consumes the hitting bit, and 0 otherwise (one-cycle pulse per hit; latency 1).
REQ-017 On every consumed bit, hist SHALL shift left and take in_bit, and fill SHALL saturate-increment to PAT_LEN-1.
REQ-018 On a hit with overlap=1, fill SHALL stay at PAT_LEN-1, so suffix overlap is detected.
REQ-019 On a hit with overlap=0, fill SHALL clear to 0, so no bit of a detected pattern is reused.
REQ-020 Cycles with in_vld=0 SHALL leave hist and fill unchanged and force match to 0 the next cycle.
REQ-021 pat_load=1 SHALL load pat from pat_data and clear fill to 0; a bit presented in the same cycle SHALL be discarded with no hit.
REQ-022 A change of overlap between bits SHALL affect only hits from the next consumed bit onward.
REQ-023 With MATCH_CNT_EN, each hit SHALL increment match_cnt by 1, saturating at 2^CNT_W-1.
REQ-024 With MATCH_CNT_EN, cnt_clr SHALL set match_cnt to 0 and SHALL win over a simultaneous hit.

Reset
REQ-025 rst SHALL set pat=PAT_INIT, hist=0, fill=0, match=0 and match_cnt=0; it SHALL take priority over all inputs.
REQ-026 Reset asserted mid-pattern SHALL discard all partial history; a hit needs PAT_LEN fresh bits after release.

Configuration
REQ-027 The macro SEQ_DET_MATCH_CNT_EN SHALL, when defined, compile in cnt_clr, match_cnt and the counter logic.
REQ-028 When SEQ_DET_MATCH_CNT_EN is undefined, neither port SHALL exist and match behaviour SHALL be identical.

Structure
REQ-029 Package seq_det_pkg SHALL hold the PAT_LEN range constants, the default pattern constant and the fill-counter width function (clog2-based).
REQ-030 Sub-module seq_det_match_cnt (saturating counter with clear) SHALL hold the counter; it is instantiated only under the macro.
REQ-031 Pattern comparison and history SHALL stay in the top module; no other sub-modules.

Verification
REQ-032 Defaults, overlap=1, bits 1,0,1,1,0,1,1 on consecutive cycles -> match pulses after bits 4 and 7; match_cnt=2.
REQ-033 Defaults, overlap=0, bits 1,0,1,1,0,1,1,0,1,1 -> match pulses after bits 4 and 10 only.
REQ-034 Bits 1,0 then in_vld=0 for 5 cycles, then 1,1 -> one match after the final bit; match stays 0 during the gap.
REQ-035 pat_load with pat_data=4'b0110 after bits 1,0,1, then bits 0,1,1,0 -> no match for 1011; match after the 0110 bit 4.
REQ-036 rst after bits 1,0,1, then bit 1 -> no match; stream 1,0,1,1 -> match.
REQ-037 CNT_W=2, macro defined, 5 hits -> match_cnt reads 3; cnt_clr together with a hit -> match_cnt=0.
